apb_master: RTL and testbench
=============================

APB_MASTER -- requirements
Module: apb_master

Interface
REQ-001 Parameters: ADDR_WIDTH, default 4, APB address width.
REQ-002 Parameters: DATA_WIDTH, default 8, APB data width (8/16/32).
REQ-003 Parameters: TIMEOUT, default 16, maximum ACCESS wait cycles before abort; 0 disables the timeout.
REQ-004 The block SHALL have one clock; reset is synchronous and active-high.
REQ-005 PCLK  input  1  APB clock; all logic on its rising edge.
REQ-006 PRESET  input  1  synchronous, active-high reset.
REQ-007 cmd_valid  input  1  command request.
REQ-008 cmd_ready  output  1  command accepted when high together with cmd_valid.
REQ-009 cmd_write  input  1  1 = write, 0 = read.
REQ-010 cmd_addr  input  ADDR_WIDTH  target address.
REQ-011 cmd_wdata  input  DATA_WIDTH  write data.
REQ-012 rsp_valid  output  1  response available.
REQ-013 rsp_ready  input  1  response consumed.
REQ-014 rsp_rdata / rsp_err / rsp_timeout  output  DATA_WIDTH/1/1  read data, slave or timeout error, timeout flag.
REQ-015 PADDR/PWRITE/PWDATA/PSELx/PENABLE  output  ADDR_WIDTH/1/DATA_WIDTH/1/1  APB requester signals.
REQ-016 PRDATA/PREADY/PSLVERR  input  DATA_WIDTH/1/1  APB completer signals.

Function
REQ-017 FSM states: IDLE, SETUP, ACCESS, RESP; one transaction in flight at a time.
REQ-018 IDLE: cmd_ready=1; on cmd_valid, capture cmd_* into PADDR/PWRITE/PWDATA (PWDATA=0 for reads) -> SETUP.
REQ-019 SETUP: PSELx=1, PENABLE=0, cmd_ready=0; unconditionally -> ACCESS next cycle.
REQ-020 ACCESS: PSELx=1, PENABLE=1; PADDR/PWRITE/PWDATA held stable from SETUP until exit.
REQ-021 ACCESS with PREADY=1: rsp_rdata <= PRDATA for reads, 0 for writes; rsp_err <= PSLVERR; rsp_timeout <= 0 -> RESP.
REQ-022 ACCESS with PREADY=0: the wait counter increments; when it equals TIMEOUT (TIMEOUT!=0), rsp_err=1, rsp_timeout=1, rsp_rdata=0 -> RESP.
REQ-023 The wait counter SHALL clear on entry to SETUP and saturate (no wrap-around); width is clog2(TIMEOUT+1), minimum 1.
REQ-024 RESP: PSELx=0, PENABLE=0, rsp_valid=1, rsp_* stable; on rsp_ready=1 -> IDLE.
REQ-025 rsp_ready held low SHALL stall in RESP indefinitely with cmd_ready=0.
REQ-026 Latency: with cmd accepted at edge T and zero-wait slave, SETUP at T+1, ACCESS at T+2, rsp_valid at T+3; minimum 4 cycles between accepted commands.
REQ-027 PREADY and PSLVERR SHALL be ignored outside ACCESS.
REQ-028 cmd_valid is ignored outside IDLE; no command is lost, because cmd_ready=0.

Reset
REQ-029 On PRESET=1 at an edge: state=IDLE, cmd_ready=1, PSELx=0, PENABLE=0, PADDR=0, PWRITE=0, PWDATA=0, rsp_valid=0, rsp_rdata=0, rsp_err=0, rsp_timeout=0, counter=0.
REQ-030 Reset mid-transaction (SETUP/ACCESS/RESP) SHALL abort with no response; the bus SHALL be idle on the following cycle.

Structure
REQ-031 The shared package apb_pkg SHALL hold the state enumeration and the UART register offsets DATA=0x0, CTRL=0x4, STAT=0x8, INT=0xC.
REQ-032 One sub-module, apb_wait_timer (clear, enable, expired), SHALL implement the wait counter.

Verification
REQ-033 Write addr 0x4, data 0x81, PREADY=1 -> PSELx rises at T+1, PENABLE at T+2; at T+3, rsp_valid=1 and rsp_err=0.
REQ-034 Read 0x8, PREADY low 3 ACCESS cycles, then high with PRDATA=0x5A -> 4 ACCESS cycles; rsp_rdata=0x5A; PADDR stable throughout.
REQ-035 Read 0x0 with PSLVERR=1, PRDATA=0xFF -> rsp_err=1, rsp_timeout=0, rsp_rdata=0xFF.
REQ-036 TIMEOUT=4, PREADY stuck low -> exit after 4 wait cycles with rsp_err=1, rsp_timeout=1, rsp_rdata=0, and PSELx=0 in RESP.
REQ-037 rsp_ready low for 5 cycles with cmd_valid high -> rsp_valid and rsp_* held, cmd_ready=0, no new SETUP.
REQ-038 PRESET pulsed during ACCESS -> next cycle PSELx=0, PENABLE=0, rsp_valid=0, cmd_ready=1.

Source files
------------

// File: rtl/apb_pkg.sv
// -----------------------------------------------------------------------------
// apb_pkg
// Shared definitions for the APB requester: FSM state encoding, the UART
// register map used by the attached peripheral, and a small width helper.
// No ports (package).
// -----------------------------------------------------------------------------
package apb_pkg;

    // Requester FSM states; exactly one transaction is in flight at a time.
    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SETUP  = 2'd1,
        ST_ACCESS = 2'd2,
        ST_RESP   = 2'd3
    } apb_state_e;

    // UART peripheral register offsets.
    localparam logic [7:0] REG_DATA = 8'h00;
    localparam logic [7:0] REG_CTRL = 8'h04;
    localparam logic [7:0] REG_STAT = 8'h08;
    localparam logic [7:0] REG_INT  = 8'h0C;

    // Width of a counter that must hold 0..timeout; never narrower than 1 bit
    // so a disabled timeout (0) still yields a legal vector.
    function automatic int cnt_width(input int timeout);
        int w;
        w = $clog2(timeout + 1);
        if (w < 1) begin
            return 1;
        end else begin
            return w;
        end
    endfunction

endpackage

// File: rtl/apb_master_if.sv
// -----------------------------------------------------------------------------
// apb_master_if
// Bundles the command/response handshake and the APB bus of the requester.
// Modports:
//   master : the apb_master block (drives cmd_ready, rsp_*, PADDR/PWRITE/
//            PWDATA/PSELx/PENABLE; receives cmd_*, rsp_ready, PRDATA/PREADY/
//            PSLVERR)
//   slave  : the environment (command source, response sink and APB completer)
// -----------------------------------------------------------------------------
interface apb_master_if #(
    parameter int ADDR_WIDTH = 4,
    parameter int DATA_WIDTH = 8
);
    // Command channel
    logic                  cmd_valid;
    logic                  cmd_ready;
    logic                  cmd_write;
    logic [ADDR_WIDTH-1:0] cmd_addr;
    logic [DATA_WIDTH-1:0] cmd_wdata;

    // Response channel
    logic                  rsp_valid;
    logic                  rsp_ready;
    logic [DATA_WIDTH-1:0] rsp_rdata;
    logic                  rsp_err;
    logic                  rsp_timeout;

    // APB bus
    logic [ADDR_WIDTH-1:0] PADDR;
    logic                  PWRITE;
    logic [DATA_WIDTH-1:0] PWDATA;
    logic                  PSELx;
    logic                  PENABLE;
    logic [DATA_WIDTH-1:0] PRDATA;
    logic                  PREADY;
    logic                  PSLVERR;

    modport master (
        input  cmd_valid, cmd_write, cmd_addr, cmd_wdata, rsp_ready,
        input  PRDATA, PREADY, PSLVERR,
        output cmd_ready, rsp_valid, rsp_rdata, rsp_err, rsp_timeout,
        output PADDR, PWRITE, PWDATA, PSELx, PENABLE
    );

    modport slave (
        output cmd_valid, cmd_write, cmd_addr, cmd_wdata, rsp_ready,
        output PRDATA, PREADY, PSLVERR,
        input  cmd_ready, rsp_valid, rsp_rdata, rsp_err, rsp_timeout,
        input  PADDR, PWRITE, PWDATA, PSELx, PENABLE
    );

endinterface

// File: rtl/apb_wait_timer.sv
// -----------------------------------------------------------------------------
// apb_wait_timer
// Counts ACCESS cycles in which the completer is not ready and flags the cycle
// in which the TIMEOUT-th such cycle occurs.
// Ports:
//   clk_i     : clock
//   rst_i     : synchronous active-high reset
//   clear_i   : restart the count (asserted on entry to SETUP)
//   enable_i  : a wait cycle is happening now (ACCESS with PREADY low)
//   expired_o : this wait cycle is the TIMEOUT-th one; never set if TIMEOUT=0
// -----------------------------------------------------------------------------
module apb_wait_timer
    import apb_pkg::*;
#(
    parameter int TIMEOUT = 16
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic clear_i,
    input  logic enable_i,
    output logic expired_o
);

    localparam int             CW         = cnt_width(TIMEOUT);
    localparam logic [CW-1:0]  CNT_MAX    = {CW{1'b1}};
    // Count value seen during the last permitted wait cycle.
    localparam logic [CW-1:0]  CNT_LAST   = (TIMEOUT > 0) ? CW'(TIMEOUT - 1) : {CW{1'b0}};
    localparam logic           TIMEOUT_EN = (TIMEOUT != 0);

    logic [CW-1:0] count_q;
    logic [CW-1:0] count_d;

    // Next count: clear wins, otherwise increment while waiting and saturate.
    always_comb begin
        count_d = count_q;
        if (clear_i) begin
            count_d = {CW{1'b0}};
        end else if (enable_i && (count_q != CNT_MAX)) begin
            count_d = count_q + CW'(1);
        end else begin
            count_d = count_q;
        end
    end

    // Count register.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            count_q <= {CW{1'b0}};
        end else begin
            count_q <= count_d;
        end
    end

    assign expired_o = TIMEOUT_EN & enable_i & (count_q == CNT_LAST);

endmodule

// File: rtl/apb_master.sv
// -----------------------------------------------------------------------------
// apb_master
// Single-outstanding APB requester. A command accepted in IDLE is driven as
// SETUP then ACCESS; the completer response (or a wait timeout) is returned
// on the response channel and held until consumed.
// Ports:
//   PCLK   : clock, all logic on rising edge
//   PRESET : synchronous active-high reset
//   bus    : apb_master_if.master (command, response and APB signals)
// Every output is a flop; control outputs are registered from the next state.
// -----------------------------------------------------------------------------
module apb_master
    import apb_pkg::*;
#(
    parameter int ADDR_WIDTH = 4,
    parameter int DATA_WIDTH = 8,
    parameter int TIMEOUT    = 16
) (
    input  logic          PCLK,
    input  logic          PRESET,
    apb_master_if.master  bus
);

    apb_state_e            state_q, state_d;
    logic [ADDR_WIDTH-1:0] paddr_q, paddr_d;
    logic                  pwrite_q, pwrite_d;
    logic [DATA_WIDTH-1:0] pwdata_q, pwdata_d;
    logic                  psel_q, psel_d;
    logic                  penable_q, penable_d;
    logic                  cmd_ready_q, cmd_ready_d;
    logic                  rsp_valid_q, rsp_valid_d;
    logic [DATA_WIDTH-1:0] rsp_rdata_q, rsp_rdata_d;
    logic                  rsp_err_q, rsp_err_d;
    logic                  rsp_timeout_q, rsp_timeout_d;

    logic timer_clear_s;
    logic timer_en_s;
    logic timer_expired_s;

    assign timer_clear_s = (state_q == ST_IDLE) & bus.cmd_valid;
    assign timer_en_s    = (state_q == ST_ACCESS) & ~bus.PREADY;

    apb_wait_timer #(
        .TIMEOUT (TIMEOUT)
    ) u_wait_timer (
        .clk_i     (PCLK),
        .rst_i     (PRESET),
        .clear_i   (timer_clear_s),
        .enable_i  (timer_en_s),
        .expired_o (timer_expired_s)
    );

    // State and output registers.
    always_ff @(posedge PCLK) begin
        if (PRESET) begin
            state_q       <= ST_IDLE;
            paddr_q       <= {ADDR_WIDTH{1'b0}};
            pwrite_q      <= 1'b0;
            pwdata_q      <= {DATA_WIDTH{1'b0}};
            psel_q        <= 1'b0;
            penable_q     <= 1'b0;
            cmd_ready_q   <= 1'b1;
            rsp_valid_q   <= 1'b0;
            rsp_rdata_q   <= {DATA_WIDTH{1'b0}};
            rsp_err_q     <= 1'b0;
            rsp_timeout_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            paddr_q       <= paddr_d;
            pwrite_q      <= pwrite_d;
            pwdata_q      <= pwdata_d;
            psel_q        <= psel_d;
            penable_q     <= penable_d;
            cmd_ready_q   <= cmd_ready_d;
            rsp_valid_q   <= rsp_valid_d;
            rsp_rdata_q   <= rsp_rdata_d;
            rsp_err_q     <= rsp_err_d;
            rsp_timeout_q <= rsp_timeout_d;
        end
    end

    // Next-state logic; PREADY is only looked at in ACCESS.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: begin
                if (bus.cmd_valid) begin
                    state_d = ST_SETUP;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_SETUP: begin
                state_d = ST_ACCESS;
            end
            ST_ACCESS: begin
                if (bus.PREADY || timer_expired_s) begin
                    state_d = ST_RESP;
                end else begin
                    state_d = ST_ACCESS;
                end
            end
            ST_RESP: begin
                if (bus.rsp_ready) begin
                    state_d = ST_IDLE;
                end else begin
                    state_d = ST_RESP;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Output logic: control flags follow the next state, bus address/data are
    // captured on acceptance and the response is captured on ACCESS exit.
    always_comb begin
        psel_d        = (state_d == ST_SETUP) | (state_d == ST_ACCESS);
        penable_d     = (state_d == ST_ACCESS);
        cmd_ready_d   = (state_d == ST_IDLE);
        rsp_valid_d   = (state_d == ST_RESP);
        paddr_d       = paddr_q;
        pwrite_d      = pwrite_q;
        pwdata_d      = pwdata_q;
        rsp_rdata_d   = rsp_rdata_q;
        rsp_err_d     = rsp_err_q;
        rsp_timeout_d = rsp_timeout_q;
        case (state_q)
            ST_IDLE: begin
                if (bus.cmd_valid) begin
                    paddr_d  = bus.cmd_addr;
                    pwrite_d = bus.cmd_write;
                    pwdata_d = bus.cmd_write ? bus.cmd_wdata : {DATA_WIDTH{1'b0}};
                end else begin
                    paddr_d  = paddr_q;
                    pwrite_d = pwrite_q;
                    pwdata_d = pwdata_q;
                end
            end
            ST_ACCESS: begin
                if (bus.PREADY) begin
                    rsp_rdata_d   = pwrite_q ? {DATA_WIDTH{1'b0}} : bus.PRDATA;
                    rsp_err_d     = bus.PSLVERR;
                    rsp_timeout_d = 1'b0;
                end else if (timer_expired_s) begin
                    rsp_rdata_d   = {DATA_WIDTH{1'b0}};
                    rsp_err_d     = 1'b1;
                    rsp_timeout_d = 1'b1;
                end else begin
                    rsp_rdata_d   = rsp_rdata_q;
                    rsp_err_d     = rsp_err_q;
                    rsp_timeout_d = rsp_timeout_q;
                end
            end
            default: begin
                paddr_d = paddr_q;
            end
        endcase
    end

    assign bus.PADDR       = paddr_q;
    assign bus.PWRITE      = pwrite_q;
    assign bus.PWDATA      = pwdata_q;
    assign bus.PSELx       = psel_q;
    assign bus.PENABLE     = penable_q;
    assign bus.cmd_ready   = cmd_ready_q;
    assign bus.rsp_valid   = rsp_valid_q;
    assign bus.rsp_rdata   = rsp_rdata_q;
    assign bus.rsp_err     = rsp_err_q;
    assign bus.rsp_timeout = rsp_timeout_q;

endmodule

// File: tb/tb_apb_master.sv
// -----------------------------------------------------------------------------
// tb_apb_master
// Directed bench for apb_master (TIMEOUT=4) with hand-computed expectations.
// -----------------------------------------------------------------------------
module tb_apb_master;
    import apb_pkg::*;

    localparam int AW  = 4;
    localparam int DW  = 8;
    localparam int TMO = 4;

    logic PCLK   = 1'b0;
    logic PRESET = 1'b1;

    always #5 PCLK = ~PCLK;

    apb_master_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) bus ();

    apb_master #(
        .ADDR_WIDTH (AW),
        .DATA_WIDTH (DW),
        .TIMEOUT    (TMO)
    ) dut (
        .PCLK   (PCLK),
        .PRESET (PRESET),
        .bus    (bus.master)
    );

    int n_total = 0;
    int n_bad   = 0;

    // Single comparison point for the whole bench.
    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h want 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge PCLK);
        #1;
    endtask

    // Present a command in IDLE, check acceptance and the SETUP phase, then
    // step into the first ACCESS cycle.
    task automatic issue(input logic w, input logic [AW-1:0] a, input logic [DW-1:0] d);
        logic [DW-1:0] exp_wd;
        exp_wd = w ? d : 8'h00;
        bus.cmd_valid = 1'b1;
        bus.cmd_write = w;
        bus.cmd_addr  = a;
        bus.cmd_wdata = d;
        chk("idle_cmd_ready", 32'(bus.cmd_ready), 32'd1);
        tick();
        bus.cmd_valid = 1'b0;
        chk("setup_psel",      32'(bus.PSELx),     32'd1);
        chk("setup_penable",   32'(bus.PENABLE),   32'd0);
        chk("setup_cmd_ready", 32'(bus.cmd_ready), 32'd0);
        chk("setup_paddr",     32'(bus.PADDR),     32'(a));
        chk("setup_pwrite",    32'(bus.PWRITE),    32'(w));
        chk("setup_pwdata",    32'(bus.PWDATA),    32'(exp_wd));
        tick();
    endtask

    // Serve ACCESS: PREADY low for 'waits' cycles then high; count ACCESS
    // cycles (bounded) and check the address stays put.
    task automatic run_access(input int waits, input logic [AW-1:0] a, output int n);
        n = 0;
        while ((bus.PENABLE === 1'b1) && (n < 20)) begin
            n++;
            chk("access_psel",  32'(bus.PSELx), 32'd1);
            chk("access_paddr", 32'(bus.PADDR), 32'(a));
            bus.PREADY = (n > waits);
            tick();
        end
        bus.PREADY = 1'b0;
    endtask

    task automatic check_resp(input logic [DW-1:0] rd, input logic err, input logic to);
        chk("resp_valid",     32'(bus.rsp_valid),   32'd1);
        chk("resp_rdata",     32'(bus.rsp_rdata),   32'(rd));
        chk("resp_err",       32'(bus.rsp_err),     32'(err));
        chk("resp_timeout",   32'(bus.rsp_timeout), 32'(to));
        chk("resp_psel",      32'(bus.PSELx),       32'd0);
        chk("resp_penable",   32'(bus.PENABLE),     32'd0);
        chk("resp_cmd_ready", 32'(bus.cmd_ready),   32'd0);
    endtask

    task automatic release_resp();
        bus.rsp_ready = 1'b1;
        tick();
        bus.rsp_ready = 1'b0;
        chk("rel_rsp_valid", 32'(bus.rsp_valid), 32'd0);
        chk("rel_cmd_ready", 32'(bus.cmd_ready), 32'd1);
        chk("rel_psel",      32'(bus.PSELx),     32'd0);
    endtask

    initial begin
        int n;
        int accepts;
        int first_acc;
        int second_acc;

        bus.cmd_valid = 1'b0;
        bus.cmd_write = 1'b0;
        bus.cmd_addr  = 4'h0;
        bus.cmd_wdata = 8'h00;
        bus.rsp_ready = 1'b0;
        bus.PRDATA    = 8'h00;
        bus.PREADY    = 1'b0;
        bus.PSLVERR   = 1'b0;

        // Reset state
        tick();
        tick();
        chk("rst_cmd_ready",   32'(bus.cmd_ready),   32'd1);
        chk("rst_psel",        32'(bus.PSELx),       32'd0);
        chk("rst_penable",     32'(bus.PENABLE),     32'd0);
        chk("rst_paddr",       32'(bus.PADDR),       32'd0);
        chk("rst_pwrite",      32'(bus.PWRITE),      32'd0);
        chk("rst_pwdata",      32'(bus.PWDATA),      32'd0);
        chk("rst_rsp_valid",   32'(bus.rsp_valid),   32'd0);
        chk("rst_rsp_rdata",   32'(bus.rsp_rdata),   32'd0);
        chk("rst_rsp_err",     32'(bus.rsp_err),     32'd0);
        chk("rst_rsp_timeout", 32'(bus.rsp_timeout), 32'd0);
        PRESET = 1'b0;
        tick();

        // Write CTRL=0x81, zero-wait; PREADY already high in SETUP is ignored
        bus.PREADY = 1'b1;
        bus.PRDATA = 8'h33;
        issue(1'b1, 4'(REG_CTRL), 8'h81);
        run_access(0, 4'(REG_CTRL), n);
        chk("wr_access_cycles", 32'(n), 32'd1);
        check_resp(8'h00, 1'b0, 1'b0);
        release_resp();

        // Read STAT with 3 wait states, data 0x5A
        bus.PRDATA = 8'h5A;
        issue(1'b0, 4'(REG_STAT), 8'hAA);
        run_access(3, 4'(REG_STAT), n);
        chk("rd_wait_access_cycles", 32'(n), 32'd4);
        check_resp(8'h5A, 1'b0, 1'b0);
        release_resp();

        // Read DATA with slave error
        bus.PSLVERR = 1'b1;
        bus.PRDATA  = 8'hFF;
        issue(1'b0, 4'(REG_DATA), 8'h00);
        run_access(0, 4'(REG_DATA), n);
        chk("slverr_access_cycles", 32'(n), 32'd1);
        check_resp(8'hFF, 1'b1, 1'b0);
        release_resp();
        bus.PSLVERR = 1'b0;

        // Timeout: PREADY never rises
        bus.PRDATA = 8'h77;
        issue(1'b0, 4'(REG_INT), 8'h00);
        run_access(1000, 4'(REG_INT), n);
        chk("tmo_access_cycles", 32'(n), 32'd4);
        check_resp(8'h00, 1'b1, 1'b1);

        // Stall in RESP with a new command pending
        bus.cmd_valid = 1'b1;
        bus.cmd_write = 1'b1;
        bus.cmd_addr  = 4'(REG_CTRL);
        bus.cmd_wdata = 8'h42;
        for (int i = 0; i < 5; i++) begin
            tick();
            check_resp(8'h00, 1'b1, 1'b1);
        end
        bus.cmd_valid = 1'b0;
        release_resp();

        // Second timeout: wait counter must restart from zero
        issue(1'b0, 4'(REG_STAT), 8'h00);
        run_access(1000, 4'(REG_STAT), n);
        chk("tmo2_access_cycles", 32'(n), 32'd4);
        check_resp(8'h00, 1'b1, 1'b1);
        release_resp();

        // Reset in the middle of ACCESS
        issue(1'b1, 4'(REG_CTRL), 8'h11);
        chk("pre_rst_penable", 32'(bus.PENABLE), 32'd1);
        PRESET = 1'b1;
        tick();
        PRESET = 1'b0;
        chk("midrst_psel",      32'(bus.PSELx),     32'd0);
        chk("midrst_penable",   32'(bus.PENABLE),   32'd0);
        chk("midrst_rsp_valid", 32'(bus.rsp_valid), 32'd0);
        chk("midrst_cmd_ready", 32'(bus.cmd_ready), 32'd1);
        chk("midrst_paddr",     32'(bus.PADDR),     32'd0);
        tick();
        chk("midrst_no_rsp",    32'(bus.rsp_valid), 32'd0);

        // Back-to-back commands: one acceptance every 4 cycles
        bus.cmd_valid = 1'b1;
        bus.cmd_write = 1'b0;
        bus.cmd_addr  = 4'(REG_DATA);
        bus.rsp_ready = 1'b1;
        bus.PREADY    = 1'b1;
        accepts    = 0;
        first_acc  = -1;
        second_acc = -1;
        for (int i = 0; i < 12; i++) begin
            if (bus.cmd_ready === 1'b1) begin
                accepts++;
                if (first_acc < 0) begin
                    first_acc = i;
                end else if (second_acc < 0) begin
                    second_acc = i;
                end
            end
            if (i == 11) begin
                bus.cmd_valid = 1'b0;
            end
            tick();
        end
        bus.rsp_ready = 1'b0;
        bus.PREADY    = 1'b0;
        chk("b2b_accepts", 32'(accepts), 32'd3);
        chk("b2b_gap",     32'(second_acc - first_acc), 32'd4);
        chk("b2b_end_idle", 32'(bus.cmd_ready), 32'd1);

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
